// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared constants and types for the fp16 adder issuer.
//                Includes the register map, the CTRL/STATUS bit positions,
//                the issuer state encoding and common fp16 values.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Register byte offsets on the peripheral bus
    localparam logic [3:0] ADDR_OPA    = 4'h0;
    localparam logic [3:0] ADDR_OPB    = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    // CTRL bit positions (write-only register)
    localparam int CTRL_START = 0;
    localparam int CTRL_ACC   = 1;
    localparam int CTRL_SUB   = 2;

    // STATUS bit positions (low half; result sits in [31:16])
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_OVR  = 3;

    // fp16 constant 1.0
    localparam logic [15:0] FP16_ONE = 16'h3C00;

    // Issuer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_add_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_add_issuer
//  Description : Bus-programmable initiator for one fp16 adder. Holds two
//                operands, issues a single valid_in pulse on START, waits for
//                the adder's valid_out (with a watchdog), captures the result
//                and reports busy/done/err/ovr status. Supports accumulate
//                (A = last result) and subtract (B sign flipped).
//                TIMEOUT must be at least 6 so a normal completion always
//                arrives before the watchdog fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_add_issuer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic [31:0] data_in,
    input  logic        data_write,
    input  logic        data_read,
    output logic [31:0] data_out,
    output logic [15:0] fa_a,
    output logic [15:0] fa_b,
    output logic        fa_valid_in,
    input  logic [15:0] fa_result,
    input  logic        fa_valid_out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    logic [15:0]   r_opa;
    logic [15:0]   r_opb;
    logic [15:0]   r_acc;
    logic [15:0]   r_result;
    logic [15:0]   r_fa_a;
    logic [15:0]   r_fa_b;
    logic          r_fa_valid_in;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_ovr;
    logic [TW-1:0] r_timer;

    logic w_wr_opa;
    logic w_wr_opb;
    logic w_start;
    logic w_stat_rd;
    logic w_idle;
    logic w_timer_last;
    logic w_unused_data;

    assign w_wr_opa     = data_write && (address == ADDR_OPA);
    assign w_wr_opb     = data_write && (address == ADDR_OPB);
    assign w_start      = data_write && (address == ADDR_CTRL) && data_in[CTRL_START];
    assign w_stat_rd    = data_read  && (address == ADDR_STATUS);
    assign w_idle       = (r_state == ST_IDLE);
    assign w_timer_last = (r_timer == TW'(TIMEOUT - 1));

    // Upper write-data bits carry nothing for any register
    assign w_unused_data = &{1'b0, data_in[31:16]};

    assign fa_a        = r_fa_a;
    assign fa_b        = r_fa_b;
    assign fa_valid_in = r_fa_valid_in;

    // Sequencer, operand registers and sticky status; later assignments in
    // this block take priority, so status sets override a same-edge read clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_opa         <= 16'h0000;
            r_opb         <= 16'h0000;
            r_acc         <= 16'h0000;
            r_result      <= 16'h0000;
            r_fa_a        <= 16'h0000;
            r_fa_b        <= 16'h0000;
            r_fa_valid_in <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_ovr         <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_fa_valid_in <= 1'b0;

            // Reading STATUS acknowledges the sticky flags
            if (w_stat_rd) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_ovr  <= 1'b0;
            end

            // Operand writes only land while idle; otherwise flag overrun
            if (w_wr_opa) begin
                if (w_idle) r_opa <= data_in[15:0];
                else        r_ovr <= 1'b1;
            end
            if (w_wr_opb) begin
                if (w_idle) r_opb <= data_in[15:0];
                else        r_ovr <= 1'b1;
            end
            if (w_start && !w_idle) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state       <= ST_ISSUE;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_err         <= 1'b0;
                        r_fa_valid_in <= 1'b1;
                        r_fa_a        <= data_in[CTRL_ACC] ? r_acc : r_opa;
                        r_fa_b        <= {r_opb[15] ^ data_in[CTRL_SUB], r_opb[14:0]};
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    // Completion is checked first so it beats a same-edge timeout
                    if (fa_valid_out) begin
                        r_result <= fa_result;
                        r_acc    <= fa_result;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_timer_last) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_timer  <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read mux, combinational on address; CTRL and unmapped offsets read 0
    always_comb begin
        data_out = 32'h0000_0000;
        case (address)
            ADDR_OPA:    data_out = {16'h0000, r_opa};
            ADDR_OPB:    data_out = {16'h0000, r_opb};
            ADDR_STATUS: data_out = {r_result, 12'h000, r_ovr, r_err, r_done, r_busy};
            default:     data_out = 32'h0000_0000;
        endcase
    end

endmodule : fpu_add_issuer
`default_nettype wire

// File: tb/tb_fpu_add_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_add_issuer
//  Description : Self-checking bench for fpu_add_issuer. A behavioural adder
//                (fixed latency, lookup of hand-computed fp16 sums, optional
//                never-respond mode) sits on the adder side. Issued operand
//                pairs are checked through a scoreboard queue; status reads
//                are checked inline against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_add_issuer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  address;
    logic [31:0] data_in;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_out;
    logic [15:0] fa_a;
    logic [15:0] fa_b;
    logic        fa_valid_in;
    logic [15:0] fa_result;
    logic        fa_valid_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {fa_a, fa_b} for each issue pulse
    logic [31:0] q_issue[$];

    // Behavioural adder controls
    logic        r_stub;
    logic        r_inject;
    logic [5:0]  r_sr;
    logic [15:0] r_sum;

    fpu_add_issuer #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_write   (data_write),
        .data_read    (data_read),
        .data_out     (data_out),
        .fa_a         (fa_a),
        .fa_b         (fa_b),
        .fa_valid_in  (fa_valid_in),
        .fa_result    (fa_result),
        .fa_valid_out (fa_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed fp16 sums for the vectors used; anything else gives NaN
    function automatic logic [15:0] sum_lut(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;  // 1 + 1 = 2
        if (a == 16'h4000 && b == 16'h3C00) return 16'h4200;  // 2 + 1 = 3
        if (a == 16'h4200 && b == 16'hBC00) return 16'h4000;  // 3 - 1 = 2
        return 16'h7E00;
    endfunction

    // Adder: valid_in sampled at E1 produces valid_out high E6..E7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= 6'd0;
            r_sum <= 16'h0000;
        end else begin
            r_sr <= {r_sr[4:0], fa_valid_in & ~r_stub};
            if (fa_valid_in) r_sum <= sum_lut(fa_a, fa_b);
        end
    end
    assign fa_valid_out = r_sr[5] | r_inject;
    assign fa_result    = r_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every issue pulse must match the next expected operand pair
    always @(negedge clk) begin
        if (rst_n && fa_valid_in) begin
            if (q_issue.size() == 0) begin
                check("unexpected_issue", {fa_a, fa_b}, 32'hxxxx_xxxx);
            end else begin
                check("issue_operands", {fa_a, fa_b}, q_issue.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    // Read with side effect; data_out checked before the clearing edge
    task automatic bus_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        address   = a;
        data_read = 1'b1;
        #1 check(name, data_out, exp);
        @(negedge clk);
        data_read = 1'b0;
    endtask

    // Side-effect-free look at a register in the current cycle
    task automatic peek(input string name, input logic [3:0] a, input logic [31:0] exp);
        address   = a;
        data_read = 1'b0;
        #1 check(name, data_out, exp);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        address = 4'hC;
        #1;
        while (data_out[0] === 1'b1 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 40) check({name, "_timeout"}, data_out, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        address    = 4'h0;
        data_in    = 32'h0;
        data_write = 1'b0;
        data_read  = 1'b0;
        r_stub     = 1'b0;
        r_inject   = 1'b0;
        repeat (3) @(negedge clk);
        peek("reset_status", 4'hC, 32'h0000_0000);
        check("reset_valid_in", {31'd0, fa_valid_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        peek("reset_opa", 4'h0, 32'h0000_0000);

        // Test 1: 1.0 + 1.0 with exact completion latency
        bus_write(4'h0, 32'hABCD_3C00);
        bus_write(4'h4, 32'h0000_3C00);
        peek("opa_readback", 4'h0, 32'h0000_3C00);
        bus_write(4'hC, 32'hFFFF_FFFF);
        peek("status_write_ignored", 4'hC, 32'h0000_0000);
        peek("ctrl_reads_zero", 4'h8, 32'h0000_0000);
        peek("unmapped_reads_zero", 4'h2, 32'h0000_0000);
        q_issue.push_back({16'h3C00, 16'h3C00});
        bus_write(4'h8, 32'h0000_0001);
        repeat (6) @(negedge clk);
        peek("t1_busy_e6", 4'hC, 32'h0000_0001);
        @(negedge clk);
        peek("t1_done_e7", 4'hC, 32'h4000_0002);

        // Test 2: accumulate, A = 2.0 from the last result
        bus_write(4'h4, 32'h0000_3C00);
        q_issue.push_back({16'h4000, 16'h3C00});
        bus_write(4'h8, 32'h0000_0003);
        wait_idle("t2");
        peek("t2_acc_result", 4'hC, 32'h4200_0002);

        // Test 3: subtract, 3.0 - 1.0
        bus_write(4'h0, 32'h0000_4200);
        q_issue.push_back({16'h4200, 16'hBC00});
        bus_write(4'h8, 32'h0000_0005);
        wait_idle("t3");
        peek("t3_sub_result", 4'hC, 32'h4000_0002);
        peek("t3_opb_unchanged", 4'h4, 32'h0000_3C00);

        // Test 4: START and an OPA write while busy are ignored, ovr set
        bus_write(4'h0, 32'h0000_3C00);
        q_issue.push_back({16'h3C00, 16'h3C00});
        bus_write(4'h8, 32'h0000_0001);
        @(negedge clk);
        bus_write(4'h8, 32'h0000_0001);
        bus_write(4'h0, 32'h0000_1234);
        wait_idle("t4");
        peek("t4_opa_kept", 4'h0, 32'h0000_3C00);
        bus_read("t4_status_preclear", 4'hC, 32'h4000_000A);
        peek("t4_status_cleared", 4'hC, 32'h4000_0000);

        // Test 5: adder never responds -> watchdog error, late completion ignored
        r_stub = 1'b1;
        q_issue.push_back({16'h3C00, 16'h3C00});
        bus_write(4'h8, 32'h0000_0001);
        repeat (15) @(negedge clk);
        peek("t5_busy_e15", 4'hC, 32'h4000_0001);
        @(negedge clk);
        peek("t5_err_e16", 4'hC, 32'h4000_0004);
        r_inject = 1'b1;
        @(negedge clk);
        r_inject = 1'b0;
        @(negedge clk);
        peek("t5_late_ignored", 4'hC, 32'h4000_0004);
        bus_read("t5_status_preclear", 4'hC, 32'h4000_0004);
        peek("t5_status_cleared", 4'hC, 32'h4000_0000);
        r_stub = 1'b0;

        // Test 6: reset during WAIT, then a clean operation
        q_issue.push_back({16'h3C00, 16'h3C00});
        bus_write(4'h8, 32'h0000_0001);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        peek("t6_reset_status", 4'hC, 32'h0000_0000);
        check("t6_reset_valid_in", {31'd0, fa_valid_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        peek("t6_no_stale_done", 4'hC, 32'h0000_0000);
        bus_write(4'h0, 32'h0000_3C00);
        bus_write(4'h4, 32'h0000_3C00);
        q_issue.push_back({16'h3C00, 16'h3C00});
        bus_write(4'h8, 32'h0000_0001);
        wait_idle("t6");
        peek("t6_after_reset", 4'hC, 32'h4000_0002);

        repeat (2) @(negedge clk);
        check("issue_queue_drained", q_issue.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule : tb_fpu_add_issuer
`default_nettype wire
